bitrev_reorder_ctl: RTL and testbench
=====================================

// Module: bitrev_reorder_ctl
// PURPOSE
//  Ping-pong reorder buffer and sequencer. Accepts blocks of 2**LOG2N samples
//  in natural order and emits each block in bit-reversed index order. Sits
//  between the FFT core and the waterfall/spectrum path.
//  Owns the bank handshake, the write/read counters and the read-address
//  bit reversal.
// PARAMETERS
//  LOG2N  10  log2 of block length N; allowed range 3..12
//  DW     32  sample width, e.g. packed {re,im}
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  in_valid   in   1      in_data valid
//  in_ready   out  1      buffer can accept in_data this cycle
//  in_data    in   DW     sample, natural order within block
//  out_valid  out  1      out_data valid
//  out_ready  in   1      downstream accepts out_data this cycle
//  out_data   out  DW     sample, bit-reversed order within block
//  out_last   out  1      qualifies final sample of a block (with out_valid)
//  blk_done   out  1      1-cycle pulse when a block's final sample is accepted
// BEHAVIOUR
//  - Storage: 2 banks x N x DW synchronous RAM, 1-cycle read latency.
//    Address is {bank, idx}.
//  - Per-bank state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
//  - Bank pointers: wbank (write), rbank (read); both reset to 0.
//  - Write side:
//    - A write occurs on in_valid & in_ready, to {wbank, wcnt}; wcnt increments.
//    - in_ready = (state[wbank] == EMPTY or FILLING), registered state only.
//    - When wcnt wraps N-1 -> 0: that bank becomes FULL and wbank toggles.
//  - Read side:
//    - Read request when state[rbank] is FULL or DRAINING,
//      rcnt not yet issued N times, and (!out_valid | out_ready).
//    - RAM address = {rbank, rev(rcnt)}, where rev() reverses the LOG2N bits
//      (bit i <- bit LOG2N-1-i).
//    - out_valid rises 1 cycle after a request.
//    - When a request is not issued, out_data/out_valid hold while
//      out_valid & !out_ready (RAM read-enable gated).
//    - out_last = out_valid & (sample index == N-1 issued).
//    - When the last sample is accepted: blk_done pulses,
//      state[rbank] -> EMPTY, rbank toggles, rcnt -> 0.
//  - Latency: first out_valid of a block is 2 cycles after the edge that
//    accepted its Nth input, provided that bank was next in line to read.
//  - Throughput: with out_ready held high, sustained 1 sample/clk, no gaps
//    between blocks (ping-pong overlap).
//  - Simultaneous events:
//    - Bank freed by a final read in the same cycle the writer is blocked on it:
//      in_ready rises the next cycle (1-cycle bubble, acceptable).
//    - Write to wbank and read of rbank in the same cycle is always legal
//      (different banks).
//  - Full: both banks FULL/DRAINING -> in_ready = 0; no data dropped.
//  - Empty: no FULL bank -> out_valid = 0 after the current sample is accepted.
//  - in_valid while in_ready = 0: ignored and held by upstream; no overflow.
//  - Reset values: in_ready = 0 during reset, 1 on the first cycle after release;
//    out_valid = 0, out_last = 0, blk_done = 0, out_data = 0.
//    All counters 0, both banks EMPTY.
//  - Reset mid-block: partial input and undrained output are discarded;
//    no out_valid until a fresh full block is written.
// TESTING (LOG2N=3, N=8)
//  1 in 0..7 back-to-back, out_ready=1 -> out 0,4,2,6,1,5,3,7; out_last on 7;
//    first out_valid 2 clk after input 7.
//  2 four blocks streamed, out_ready=1 -> 32 outputs, no idle cycles between
//    blocks after the first; blk_done x4.
//  3 out_ready=0, three blocks offered -> in_ready drops after 16 accepted;
//    release -> blocks 1,2 then 3 intact, none lost or duplicated.
//  4 random in_valid/out_ready toggling, 200 blocks -> scoreboard of
//    bit-reversed order matches; out_data stable while stalled.
//  5 assert reset after 5 inputs of block 2 and mid-drain of block 1 ->
//    out_valid=0 immediately; next block 100..107 emerges as
//    100,104,102,106,101,105,103,107.
//  6 LOG2N=10 regression: ramp 0..1023 -> out[k] = rev10(k); out_last at k=1023.

Source files
------------

// File: rtl/bitrev_reorder_ctl.sv
// Ping-pong reorder buffer: blocks of 2**LOG2N samples arrive in natural order
// and leave in bit-reversed index order, one bank filling while the other drains.
module bitrev_reorder_ctl #(
    parameter int LOG2N = 10,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          blk_done
);

    localparam int N = 1 << LOG2N;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; a valid source holds its data until that edge, and ready
    // never depends combinationally on valid.

    bank_state_t          state_q [2];
    bank_state_t          state_d [2];
    logic                 wbank_q;
    logic                 rbank_q;
    logic [LOG2N-1:0]     wcnt_q;
    logic [LOG2N-1:0]     rcnt_q;
    logic                 wr_fire;
    logic                 rd_req;
    logic [LOG2N:0]       waddr;
    logic [LOG2N:0]       raddr;
    logic [DW-1:0]        mem [2*N];

    function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    assign in_ready = !reset &&
                      (state_q[wbank_q] == EMPTY || state_q[wbank_q] == FILLING);
    assign wr_fire  = in_valid && in_ready;
    assign rd_req   = (state_q[rbank_q] == FULL || state_q[rbank_q] == DRAINING) &&
                      (!out_valid || out_ready);
    assign blk_done = out_valid && out_ready && out_last;
    assign waddr    = {wbank_q, wcnt_q};
    assign raddr    = {rbank_q, rev(rcnt_q)};

    // A bank is released once its final RAM read has been issued: the sample
    // already sits in the output register, so the writer can refill the bank
    // at once and blocks stream back-to-back without a gap.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        if (wr_fire) begin
            state_d[wbank_q] = (&wcnt_q) ? FULL : FILLING;
        end
        if (rd_req) begin
            state_d[rbank_q] = (&rcnt_q) ? EMPTY : DRAINING;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            if (wr_fire) begin
                wcnt_q <= wcnt_q + 1'b1;
                if (&wcnt_q) begin
                    wbank_q <= ~wbank_q;
                end
            end
            if (rd_req) begin
                rcnt_q <= rcnt_q + 1'b1;
                if (&rcnt_q) begin
                    rbank_q <= ~rbank_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[waddr] <= in_data;
        end
    end

    // Output register doubles as the RAM read port; it only loads on a request,
    // so data holds while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (rd_req) begin
            out_valid <= 1'b1;
            out_last  <= &rcnt_q;
            out_data  <= mem[raddr];
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bitrev_reorder_ctl.sv
// Bench for bitrev_reorder_ctl: an N=8 instance for the functional scenarios
// and an N=1024 instance for the large-block ramp.
module tb_bitrev_reorder_ctl;

    localparam int L_A = 3;
    localparam int N_A = 8;
    localparam int L_B = 10;
    localparam int N_B = 1024;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_blk_done;
    logic [DW-1:0] a_in_data, a_out_data;
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_blk_done;
    logic [DW-1:0] b_in_data, b_out_data;

    bitrev_reorder_ctl #(.LOG2N(L_A), .DW(DW)) dut_a (
        .clk(clk), .reset(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .blk_done(a_blk_done)
    );

    bitrev_reorder_ctl #(.LOG2N(L_B), .DW(DW)) dut_b (
        .clk(clk), .reset(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .blk_done(b_blk_done)
    );

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] in_buf[$];
    int out_idx = 0;

    // Bit reversal as plain arithmetic on an integer index.
    function automatic int rev_idx(input int k, input int l);
        int r = 0;
        for (int i = 0; i < l; i++) begin
            if (((k >> i) & 1) != 0) r = r + (1 << (l - 1 - i));
        end
        return r;
    endfunction

    task automatic model_push(input logic [DW-1:0] d);
        in_buf.push_back(d);
        if (in_buf.size() == N_A) begin
            for (int k = 0; k < N_A; k++) exp_q.push_back(in_buf[rev_idx(k, L_A)]);
            in_buf.delete();
        end
    endtask

    // One clock of the N=8 instance: drive, sample 1 time unit later, return at the next negedge.
    task automatic step_a(input bit iv, input logic [DW-1:0] id, input bit ordy,
                          output bit in_acc, output bit out_acc, output logic ov,
                          output logic [DW-1:0] od, output logic ol, output logic bd);
        a_in_valid  = iv;
        a_in_data   = id;
        a_out_ready = ordy;
        #1;
        in_acc  = iv && (a_in_ready === 1'b1);
        out_acc = (a_out_valid === 1'b1) && ordy;
        ov = a_out_valid;
        od = a_out_data;
        ol = a_out_last;
        bd = a_blk_done;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", a_out_last); end
        checks++; if (a_blk_done !== 1'b0) begin failures++; $display("FAIL reset_blk_done got=%b exp=0", a_blk_done); end
        checks++; if (a_out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", a_out_data); end
        checks++; if (b_in_ready !== 1'b0) begin failures++; $display("FAIL reset_b_in_ready got=%b exp=0", b_in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", a_in_ready); end
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL release_b_in_ready got=%b exp=1", b_in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single_block();
        int exp_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int cyc = 0, sent = 0, nout = 0, acc7 = -1, first_ov = -1;
        bit in_acc, out_acc;
        logic ov, ol, bd;
        logic [DW-1:0] od;
        while (nout < 8 && cyc < 100) begin
            step_a(sent < 8, DW'(sent), 1'b1, in_acc, out_acc, ov, od, ol, bd);
            if (in_acc) begin
                if (sent == 7) acc7 = cyc;
                sent++;
            end
            if (ov === 1'b1 && first_ov < 0) first_ov = cyc;
            if (out_acc) begin
                checks++; if (od !== DW'(exp_tab[nout])) begin failures++; $display("FAIL single_data[%0d] got=%0h exp=%0h", nout, od, exp_tab[nout]); end
                checks++; if (ol !== (nout == 7)) begin failures++; $display("FAIL single_last[%0d] got=%b exp=%b", nout, ol, nout == 7); end
                checks++; if (bd !== (nout == 7)) begin failures++; $display("FAIL single_blk_done[%0d] got=%b exp=%b", nout, bd, nout == 7); end
                nout++;
            end
            cyc++;
        end
        a_in_valid = 0;
        checks++; if (nout != 8) begin failures++; $display("FAIL single_timeout got=%0d outputs exp=8", nout); end
        checks++; if (first_ov - acc7 != 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", first_ov - acc7); end
    endtask

    // Random-data streaming scored against the reference queue; hold>0 keeps
    // out_ready low for that many cycles first, gapless demands continuous output.
    task automatic test_stream(input string name, input int nblk, input int vpct,
                               input int rpct, input int hold, input bit gapless);
        int total = nblk * N_A;
        int sent = 0, nout = 0, ndone = 0, cyc = 0;
        bit in_acc, out_acc, iv, ordy, started = 0, prev_stall = 0;
        logic ov, ol, bd;
        logic [DW-1:0] od, prev_od = '0, expv;
        logic [DW-1:0] cur = $urandom;
        exp_q.delete(); in_buf.delete(); out_idx = 0;
        while (nout < total && cyc < 20000) begin
            iv   = (sent < total) && (int'($urandom_range(99)) < vpct);
            ordy = (cyc >= hold) && (int'($urandom_range(99)) < rpct);
            step_a(iv, cur, ordy, in_acc, out_acc, ov, od, ol, bd);
            if (prev_stall) begin
                checks++;
                if (ov !== 1'b1 || od !== prev_od) begin
                    failures++; $display("FAIL %s stall_hold got=%b/%0h exp=1/%0h", name, ov, od, prev_od);
                end
            end
            if (in_acc) begin model_push(cur); sent++; cur = $urandom; end
            if (hold > 0 && cyc == hold - 1) begin
                checks++; if (sent != 2 * N_A) begin failures++; $display("FAIL %s held_accepts got=%0d exp=%0d", name, sent, 2 * N_A); end
                checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL %s held_in_ready got=%b exp=0", name, a_in_ready); end
            end
            if (gapless && started) begin
                checks++; if (ov !== 1'b1) begin failures++; $display("FAIL %s gap at output %0d got=%b exp=1", name, nout, ov); end
            end
            if (ov === 1'b1) started = 1;
            if (out_acc) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL %s unexpected_output got=%0h exp=none", name, od);
                end else begin
                    expv = exp_q.pop_front();
                    if (od !== expv) begin failures++; $display("FAIL %s data[%0d] got=%0h exp=%0h", name, nout, od, expv); end
                end
                checks++; if (ol !== (out_idx == N_A - 1)) begin failures++; $display("FAIL %s last[%0d] got=%b exp=%b", name, nout, ol, out_idx == N_A - 1); end
                checks++; if (bd !== (out_idx == N_A - 1)) begin failures++; $display("FAIL %s blk_done[%0d] got=%b exp=%b", name, nout, bd, out_idx == N_A - 1); end
                if (bd === 1'b1) ndone++;
                out_idx = (out_idx + 1) % N_A;
                nout++;
            end else begin
                checks++; if (bd !== 1'b0) begin failures++; $display("FAIL %s spurious_blk_done got=%b exp=0", name, bd); end
            end
            prev_stall = (ov === 1'b1) && !ordy;
            prev_od = od;
            cyc++;
        end
        a_in_valid = 0; a_out_ready = 0;
        checks++; if (nout != total) begin failures++; $display("FAIL %s timeout got=%0d exp=%0d", name, nout, total); end
        checks++; if (ndone != nblk) begin failures++; $display("FAIL %s blk_done_count got=%0d exp=%0d", name, ndone, nblk); end
        checks++; if (exp_q.size() != 0 || in_buf.size() != 0) begin failures++; $display("FAIL %s leftover got=%0d exp=0", name, exp_q.size() + in_buf.size()); end
    endtask

    task automatic test_reset_mid_block();
        int exp_tab[8] = '{100, 104, 102, 106, 101, 105, 103, 107};
        int acc = 0, sent = 0, nout = 0, cyc = 0;
        bit in_acc, out_acc;
        logic ov, ol, bd;
        logic [DW-1:0] od;
        for (int i = 0; i < 13; i++) begin
            step_a(1'b1, DW'(10 + i), 1'b0, in_acc, out_acc, ov, od, ol, bd);
            if (in_acc) acc++;
        end
        checks++; if (acc != 13) begin failures++; $display("FAIL midreset_accepts got=%0d exp=13", acc); end
        for (int i = 0; i < 2; i++) step_a(1'b0, '0, 1'b1, in_acc, out_acc, ov, od, ol, bd);
        rst = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL midreset_in_ready got=%b exp=0", a_in_ready); end
        @(negedge clk);
        rst = 1'b0;
        while (nout < 8 && cyc < 100) begin
            step_a(sent < 8, DW'(100 + sent), 1'b1, in_acc, out_acc, ov, od, ol, bd);
            if (sent < 8) begin
                checks++; if (ov !== 1'b0) begin failures++; $display("FAIL midreset_stale_valid got=%b exp=0", ov); end
            end
            if (in_acc) sent++;
            if (out_acc) begin
                checks++; if (od !== DW'(exp_tab[nout])) begin failures++; $display("FAIL midreset_data[%0d] got=%0d exp=%0d", nout, od, exp_tab[nout]); end
                checks++; if (ol !== (nout == 7)) begin failures++; $display("FAIL midreset_last[%0d] got=%b exp=%b", nout, ol, nout == 7); end
                nout++;
            end
            cyc++;
        end
        a_in_valid = 0;
        checks++; if (nout != 8) begin failures++; $display("FAIL midreset_timeout got=%0d exp=8", nout); end
    endtask

    task automatic test_log2n10();
        int sent = 0, k = 0, cyc = 0;
        while (k < N_B && cyc < 3000) begin
            b_in_valid  = (sent < N_B);
            b_in_data   = DW'(sent);
            b_out_ready = 1'b1;
            #1;
            if (b_in_valid && b_in_ready === 1'b1) sent++;
            if (b_out_valid === 1'b1) begin
                checks++; if (b_out_data !== DW'(rev_idx(k, L_B))) begin failures++; $display("FAIL n1024_data[%0d] got=%0d exp=%0d", k, b_out_data, rev_idx(k, L_B)); end
                checks++; if (b_out_last !== (k == N_B - 1)) begin failures++; $display("FAIL n1024_last[%0d] got=%b exp=%b", k, b_out_last, k == N_B - 1); end
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        b_in_valid = 0; b_out_ready = 0;
        checks++; if (k != N_B) begin failures++; $display("FAIL n1024_timeout got=%0d exp=%0d", k, N_B); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_stream("back_to_back", 4, 100, 100, 0, 1'b1);
        test_stream("backpressure", 3, 100, 100, 40, 1'b0);
        test_stream("random", 200, 60, 60, 0, 1'b0);
        test_reset_mid_block();
        test_log2n10();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
